// File: rtl/sdpram_pkg.sv
// Shared sizing defaults and word type for the 2k x 9 simple dual-port RAM.
package sdpram_pkg;

    localparam int ADDR_WIDTH_DEF = 11;
    localparam int DATA_WIDTH_DEF = 9;
    localparam int DEPTH_DEF      = 2 ** ADDR_WIDTH_DEF;

    typedef logic [DATA_WIDTH_DEF-1:0] word_t;

    function automatic int depth_of(input int addr_width);
        return 2 ** addr_width;
    endfunction

endpackage

// File: rtl/sdpram_2k_x9_if.sv
// Write and read port bundle; clocks and resets stay outside as plain ports.
interface sdpram_2k_x9_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 9
);

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_clk_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;

    modport master (
        output wr_en, wr_addr, wr_data, rd_clk_en, rd_addr,
        input  rd_data
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_clk_en, rd_addr,
        output rd_data
    );

endinterface

// File: rtl/sdpram_core.sv
// Bare storage array with a registered read; kept reset-free so it maps onto block RAM.
module sdpram_core
    import sdpram_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  wr_clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_clk,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_q_p0
);

    localparam int DEPTH = depth_of(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge wr_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read samples the array before any same-edge write lands: read-before-write.
    always_ff @(posedge rd_clk) begin
        if (rd_en) begin
            rd_q_p0 <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sdpram_2k_x9.sv
// 2048 x 9 simple dual-port RAM: write gating, read reset masking and optional output register.
module sdpram_2k_x9
    import sdpram_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter bit OUTPUT_REG = 1'b0
) (
    input  logic                 wr_clk,
    input  logic                 tb_wr_rst,
    input  logic                 rd_clk,
    input  logic                 rd_rst,
    sdpram_2k_x9_if.slave        bus
);

    logic                  wr_en_g;
    logic [DATA_WIDTH-1:0] core_q_p0;
    logic                  vld_p0;
    logic [DATA_WIDTH-1:0] rd_p0;

    // Level-gated so a reset still high on its release edge blocks that write too.
    assign wr_en_g = bus.wr_en & ~tb_wr_rst;

    sdpram_core #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
        .wr_clk  (wr_clk),
        .wr_en   (wr_en_g),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_clk  (rd_clk),
        .rd_en   (bus.rd_clk_en),
        .rd_addr (bus.rd_addr),
        .rd_q_p0 (core_q_p0)
    );

    // The array register cannot take an async reset, so a flag masks it to zero
    // from rd_rst until the first enabled read edge after release.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            vld_p0 <= 1'b0;
        end else if (bus.rd_clk_en) begin
            vld_p0 <= 1'b1;
        end
    end

    assign rd_p0 = vld_p0 ? core_q_p0 : '0;

    // ---- stage p0 -> p1 ----
    generate
        if (OUTPUT_REG) begin : g_oreg
            logic [DATA_WIDTH-1:0] rd_q_p1;

            always_ff @(posedge rd_clk or posedge rd_rst) begin
                if (rd_rst) begin
                    rd_q_p1 <= '0;
                end else if (bus.rd_clk_en) begin
                    rd_q_p1 <= rd_p0;
                end
            end

            assign bus.rd_data = rd_q_p1;
        end else begin : g_noreg
            assign bus.rd_data = rd_p0;
        end
    endgenerate

endmodule

// File: tb/tb_sdpram_2k_x9.sv
// Bench for sdpram_2k_x9: drives a 1-cycle and a 2-cycle build in lockstep against an array model.
module tb_sdpram_2k_x9;
    import sdpram_pkg::*;

    logic wr_clk = 1'b0;
    logic rd_clk = 1'b0;
    logic tb_wr_rst;
    logic rd_rst;

    always #5 wr_clk = ~wr_clk;
    always #5 rd_clk = ~rd_clk;

    sdpram_2k_x9_if #(.ADDR_WIDTH(11), .DATA_WIDTH(9)) bus0 ();
    sdpram_2k_x9_if #(.ADDR_WIDTH(11), .DATA_WIDTH(9)) bus1 ();

    assign bus1.wr_en     = bus0.wr_en;
    assign bus1.wr_addr   = bus0.wr_addr;
    assign bus1.wr_data   = bus0.wr_data;
    assign bus1.rd_clk_en = bus0.rd_clk_en;
    assign bus1.rd_addr   = bus0.rd_addr;

    sdpram_2k_x9 #(.OUTPUT_REG(1'b0)) dut0 (
        .wr_clk    (wr_clk),
        .tb_wr_rst (tb_wr_rst),
        .rd_clk    (rd_clk),
        .rd_rst    (rd_rst),
        .bus       (bus0)
    );

    sdpram_2k_x9 #(.OUTPUT_REG(1'b1)) dut1 (
        .wr_clk    (wr_clk),
        .tb_wr_rst (tb_wr_rst),
        .rd_clk    (rd_clk),
        .rd_rst    (rd_rst),
        .bus       (bus1)
    );

    // Reference: the memory contents plus what each build should be showing.
    word_t mem_m [DEPTH_DEF];
    word_t exp0;
    word_t exp1;
    int    checks;
    int    fails;

    task automatic chk(input string tag, input word_t obs, input word_t exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive after the falling edge, let the model take the rising edge, check at the next fall.
    task automatic step(input logic we, input int wa, input word_t wd,
                        input logic re, input int ra, input string tag);
        bus0.wr_en     = we;
        bus0.wr_addr   = wa[10:0];
        bus0.wr_data   = wd;
        bus0.rd_clk_en = re;
        bus0.rd_addr   = ra[10:0];
        @(posedge rd_clk);
        if (!rd_rst && re) begin
            exp1 = exp0;
            exp0 = mem_m[ra];
        end
        if (we && !tb_wr_rst) begin
            mem_m[wa] = wd;
        end
        @(negedge rd_clk);
        chk({tag, "/lat1"}, bus0.rd_data, exp0);
        chk({tag, "/lat2"}, bus1.rd_data, exp1);
    endtask

    initial begin
        checks         = 0;
        fails          = 0;
        exp0           = '0;
        exp1           = '0;
        tb_wr_rst      = 1'b1;
        rd_rst         = 1'b1;
        bus0.wr_en     = 1'b0;
        bus0.wr_addr   = '0;
        bus0.wr_data   = '0;
        bus0.rd_clk_en = 1'b0;
        bus0.rd_addr   = '0;
        foreach (mem_m[i]) mem_m[i] = '0;

        // Both resets held for 200 ns while the bus is busy: output stays zero, writes are dropped.
        @(negedge rd_clk);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, int'($urandom_range(0, 2047)), word_t'($urandom),
                 1'b1, int'($urandom_range(0, 2047)), "in_reset");
        end
        tb_wr_rst = 1'b0;
        rd_rst    = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 0, '0, 1'b0, 0, "post_reset_idle");

        // Write sweep 1..2047 then 0 with 511 down to 0.
        for (int i = 0; i < 2048; i++) begin
            step(1'b1, (i + 1) % 2048, word_t'(511 - i), 1'b0, 0, "wr_sweep");
        end

        // Read sweep in the same order, with a 5-cycle clock-enable gap in the middle.
        for (int i = 0; i < 2048; i++) begin
            if (i == 1000) begin
                for (int k = 0; k < 5; k++) begin
                    step(1'b0, 0, '0, 1'b0, int'($urandom_range(0, 2047)), "rd_hold");
                end
            end
            step(1'b0, 0, '0, 1'b1, (i + 1) % 2048, "rd_sweep");
        end
        step(1'b0, 0, '0, 1'b1, 2047, "rd_flush");
        chk("addr2047_const", bus0.rd_data, 9'd1);

        // Same-edge write and read of one address returns the old word.
        step(1'b1, 5, 9'h0AA, 1'b0, 0, "coll_setup");
        step(1'b1, 5, 9'h155, 1'b1, 5, "coll_same_edge");
        chk("coll_old_const", bus0.rd_data, 9'h0AA);
        step(1'b0, 0, '0, 1'b1, 5, "coll_next");
        chk("coll_new_const", bus0.rd_data, 9'h155);

        // Read reset pulsed between edges during a burst.
        for (int a = 10; a < 14; a++) step(1'b0, 0, '0, 1'b1, a, "pre_rd_rst");
        rd_rst = 1'b1;
        #1;
        exp0 = '0;
        exp1 = '0;
        chk("rd_rst_async/lat1", bus0.rd_data, '0);
        chk("rd_rst_async/lat2", bus1.rd_data, '0);
        step(1'b0, 0, '0, 1'b1, 11, "rd_rst_held");
        step(1'b0, 0, '0, 1'b1, 12, "rd_rst_held");
        rd_rst = 1'b0;
        for (int a = 10; a < 14; a++) step(1'b0, 0, '0, 1'b1, a, "post_rd_rst");

        // Write reset with wr_en high leaves the word alone.
        tb_wr_rst = 1'b1;
        step(1'b1, 7, ~mem_m[7], 1'b0, 0, "wr_rst_write");
        tb_wr_rst = 1'b0;
        step(1'b0, 0, '0, 1'b1, 7, "wr_rst_readback");
        step(1'b0, 0, '0, 1'b1, 7, "wr_rst_readback");

        // Mixed random traffic over a small window to provoke collisions.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom), int'($urandom_range(0, 15)), word_t'($urandom),
                 1'($urandom), int'($urandom_range(0, 15)), "random");
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
